gate_truth_scanner: RTL and testbench

GATE_TRUTH_SCANNER -- requirements
Module: gate_truth_scanner

---
 rtl/gate_truth_scanner.sv | 157 +++++++++++++++
 tb/tb_gate_truth_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_scanner.sv
// gate_truth_scanner
// Drives the four input vectors {a,b} = 00, 01, 10, 11 onto an external
// 2-input gate, waits SETTLE cycles per vector, and samples the gate output.
// It captures the resulting truth table and compares it with an expected
// table that is latched at start.
//
// Timing per vector: SETTLE cycles in SETTLE state, then one CAPTURE cycle.
// This gives SETTLE+1 cycles per vector and 4*(SETTLE+1) cycles from the
// start-accepting edge to the DONE cycle.
module gate_truth_scanner #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] exp,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_out,
  output logic       pass,
  output logic [2:0] mismatch_cnt
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Last settle-counter value before the capture cycle. The legal SETTLE
  // range (1..15) keeps this inside 4 bits.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // Number of ones in a 4-bit word; the result fits in 3 bits (max 4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] sum;
    sum = 3'd0;
    for (int i = 0; i < 4; i++) begin
      sum = sum + {2'd0, v[i]};
    end
    return sum;
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] exp_q, exp_d;
  logic [1:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] table_q, table_d;
  logic       pass_q, pass_d;
  logic [2:0] mism_q, mism_d;

  // Next-state and datapath logic for the scan sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    vec_d   = vec_q;
    table_d = table_q;
    pass_d  = pass_q;
    mism_d  = mism_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          exp_d   = exp;
          table_d = 4'b0000;
          pass_d  = 1'b0;
          mism_d  = 3'd0;
          idx_d   = 2'd0;
          vec_d   = 2'b00;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_CAPTURE: begin
        table_d[idx_q] = gate_y;
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          vec_d   = idx_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = ST_SETTLE;
        end else begin
          // The verdict uses the freshly completed table so it is ready in DONE.
          state_d = ST_DONE;
          pass_d  = (table_d == exp_q);
          mism_d  = popcount4(table_d ^ exp_q);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      exp_q   <= 4'b0000;
      vec_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= 4'b0000;
      pass_q  <= 1'b0;
      mism_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      pass_q  <= pass_d;
      mism_q  <= mism_d;
    end
  end

  assign gate_a       = vec_q[1];
  assign gate_b       = vec_q[0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mism_q;

endmodule

// File: tb/tb_gate_truth_scanner.sv
// Self-checking bench for gate_truth_scanner.
// Instance u0 uses SETTLE=2 and instance u1 uses SETTLE=1. Each instance
// drives a behavioural gate whose truth table is held in tt0 or tt1.
module tb_gate_truth_scanner;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0, gate_y0, ga0, gb0, busy0, done0, pass0;
  logic [3:0] exp0, tab0, tt0;
  logic [2:0] mm0;
  logic       start1, gate_y1, ga1, gb1, busy1, done1, pass1;
  logic [3:0] exp1, tab1, tt1;
  logic [2:0] mm1;

  int n_checks = 0;
  int n_fail   = 0;

  assign gate_y0 = tt0[{ga0, gb0}];
  assign gate_y1 = tt1[{ga1, gb1}];

  gate_truth_scanner #(.SETTLE(S0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .exp(exp0), .gate_y(gate_y0),
    .gate_a(ga0), .gate_b(gb0), .busy(busy0), .done(done0),
    .table_out(tab0), .pass(pass0), .mismatch_cnt(mm0)
  );

  gate_truth_scanner #(.SETTLE(S1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .exp(exp1), .gate_y(gate_y1),
    .gate_a(ga1), .gate_b(gb1), .busy(busy1), .done(done1),
    .table_out(tab1), .pass(pass1), .mismatch_cnt(mm1)
  );

  task automatic test_reset;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    exp0 = 4'h0; exp1 = 4'h0; tt0 = 4'b0110; tt1 = 4'b0110;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ga0, gb0, busy0, done0, tab0, pass0, mm0} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_u0: got %h expected 000", {ga0, gb0, busy0, done0, tab0, pass0, mm0});
    end
    n_checks++;
    if ({ga1, gb1, busy1, done1, tab1, pass1, mm1} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_u1: got %h expected 000", {ga1, gb1, busy1, done1, tab1, pass1, mm1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy0, done0, busy1, done1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected 0000", {busy0, done0, busy1, done1});
    end
  endtask

  // Full scan on u0; expected results come straight from the gate's truth table.
  task automatic test_scan(input logic [3:0] tt, input logic [3:0] ev, input string nm);
    int         len;
    logic [2:0] exp_mm;
    logic       exp_pass;
    len      = 4 * (S0 + 1);
    exp_pass = (tt == ev);
    exp_mm   = 3'($countones(tt ^ ev));
    tt0 = tt;
    @(negedge clk); start0 = 1'b1; exp0 = ev;
    @(negedge clk); start0 = 1'b0; exp0 = ~ev;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) @(negedge clk);
      if (k < len) begin
        n_checks++;
        if ({ga0, gb0, busy0, done0, pass0, mm0} !== {2'(k / (S0 + 1)), 1'b1, 1'b0, 1'b0, 3'd0}) begin
          n_fail++;
          $display("FAIL %s_vec k=%0d: got ab=%b busy=%b done=%b pass=%b mm=%0d expected ab=%b busy=1 done=0 pass=0 mm=0",
                   nm, k, {ga0, gb0}, busy0, done0, pass0, mm0, 2'(k / (S0 + 1)));
        end
      end else begin
        n_checks++;
        if ({busy0, done0} !== 2'b11) begin
          n_fail++;
          $display("FAIL %s_latency: busy/done=%b at cycle %0d expected 11", nm, {busy0, done0}, k);
        end
        n_checks++;
        if ({tab0, pass0, mm0} !== {tt, exp_pass, exp_mm}) begin
          n_fail++;
          $display("FAIL %s_result: got table=%b pass=%b mm=%0d expected table=%b pass=%b mm=%0d",
                   nm, tab0, pass0, mm0, tt, exp_pass, exp_mm);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if ({busy0, done0, ga0, gb0} !== 4'b0011) begin
      n_fail++;
      $display("FAIL %s_after_done: got busy,done,a,b=%b expected 0011", nm, {busy0, done0, ga0, gb0});
    end
    exp0 = 4'($urandom);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tab0, pass0, mm0, done0} !== {tt, exp_pass, exp_mm, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_hold: got table=%b pass=%b mm=%0d done=%b expected table=%b pass=%b mm=%0d done=0",
               nm, tab0, pass0, mm0, done0, tt, exp_pass, exp_mm);
    end
  endtask

  task automatic test_patterns;
    logic [3:0] tt, ev;
    test_scan(4'b0110, 4'b0110, "xor");
    test_scan(4'b1000, 4'b0110, "and");
    test_scan(4'b0000, 4'b1111, "all_diff");
    for (int i = 0; i < 6; i++) begin
      tt = 4'($urandom);
      ev = (i % 3 == 0) ? tt : 4'($urandom);
      test_scan(tt, ev, "random");
    end
  endtask

  // Start pulses during SETTLE (cycle 3) and in the DONE cycle must be ignored.
  task automatic test_start_ignored;
    int len, n_done;
    len = 4 * (S0 + 1);
    n_done = 0;
    tt0 = 4'b0110;
    @(negedge clk); start0 = 1'b1; exp0 = 4'b0110;
    @(negedge clk); start0 = 1'b0;
    for (int k = 0; k <= len + 20; k++) begin
      if (k > 0) @(negedge clk);
      n_done += int'(done0);
      if (k == len + 1) begin
        n_checks++;
        if (busy0 !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_busy_drop: got busy=%b expected 0", busy0);
        end
      end
      start0 = (k == 3 || k == len) ? 1'b1 : 1'b0;
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d pulses expected 1", n_done);
    end
    n_checks++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_queue: got busy=%b expected 0", busy0);
    end
  endtask

  // Reset during the 10 vector aborts the scan; start on the first edge after release.
  task automatic test_reset_mid;
    int n_done, seen;
    n_done = 0;
    tt0 = 4'b0110;
    @(negedge clk); start0 = 1'b1; exp0 = 4'b0110;
    @(negedge clk); start0 = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++;
    if ({ga0, gb0} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_phase: got ab=%b expected 10", {ga0, gb0});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ga0, gb0, busy0, done0, tab0, pass0, mm0} !== 12'h000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h expected 000", {ga0, gb0, busy0, done0, tab0, pass0, mm0});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_done += int'(done0);
    end
    rst_n = 1'b1; start0 = 1'b1; exp0 = 4'b0110;
    @(negedge clk); start0 = 1'b0;
    n_checks++;
    if ({busy0, ga0, gb0} !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_first_edge: got busy,a,b=%b expected 100", {busy0, ga0, gb0});
    end
    seen = 0;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) seen = k;
    end
    n_checks++;
    if (seen != 4 * (S0 + 1) || n_done != 0) begin
      n_fail++;
      $display("FAIL rstmid_rescan: done at cycle %0d (pulses in reset %0d) expected %0d (0)",
               seen, n_done, 4 * (S0 + 1));
    end
    n_checks++;
    if ({tab0, pass0, mm0} !== {4'b0110, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL rstmid_result: got table=%b pass=%b mm=%0d expected 0110 1 0", tab0, pass0, mm0);
    end
    repeat (2) @(negedge clk);
  endtask

  // Held start on the SETTLE=1 instance: 8-cycle scan, DONE, one IDLE cycle, repeat.
  task automatic test_back_to_back;
    int   m, per;
    logic exp_done, exp_busy;
    logic [1:0] exp_ab;
    per = 4 * (S1 + 1) + 2;
    tt1 = 4'b0110;
    exp1 = 4'b0110;
    @(negedge clk); start1 = 1'b1;
    for (int c = 0; c < 3 * per + 8; c++) begin
      @(negedge clk);
      m        = c % per;
      exp_done = (m == 4 * (S1 + 1));
      exp_busy = (m != per - 1);
      exp_ab   = (m < 4 * (S1 + 1)) ? 2'(m / (S1 + 1)) : 2'b11;
      n_checks++;
      if ({ga1, gb1, busy1, done1} !== {exp_ab, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL b2b c=%0d: got ab=%b busy=%b done=%b expected ab=%b busy=%b done=%b",
                 c, {ga1, gb1}, busy1, done1, exp_ab, exp_busy, exp_done);
      end
      if (exp_done) begin
        n_checks++;
        if ({pass1, mm1, tab1} !== {1'b1, 3'd0, 4'b0110}) begin
          n_fail++;
          $display("FAIL b2b_pass c=%0d: got pass=%b mm=%0d table=%b expected 1 0 0110", c, pass1, mm1, tab1);
        end
      end
      if (c == 3 * per + 7) start1 = 1'b0;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: got busy=%b expected 0", busy1);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
